// File: rtl/microcode_rom_if.sv
// Lookup and patch bus between the control unit and the microcode store.
// The master drives the opcode and write port; the slave returns the registered control word.
interface microcode_rom_if #(
    parameter int CS_N = 1
);
    logic [3:0]    opcode;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [CS_N:0] wr_data;
    logic [CS_N:0] control_signals;

    modport master (
        output opcode,
        output wr_en,
        output wr_addr,
        output wr_data,
        input  control_signals
    );

    modport slave (
        input  opcode,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output control_signals
    );
endinterface

// File: rtl/microcode_rom.sv
// 16-entry patchable microcode store: registered opcode -> control-word lookup,
// read-before-write on same-address patches, entry 0 pinned to all-zero.
module microcode_rom #(
    parameter int CS_N = 1
) (
    input  logic            clk,
    input  logic            reset,
    microcode_rom_if.slave  bus
);
    logic [CS_N:0] r_table [16];
    logic [CS_N:0] r_cs;
    logic          w_wr_ok;

    // Default entry i is i zero-extended or truncated to the word width.
    function automatic logic [CS_N:0] dflt(input logic [3:0] idx);
        logic [CS_N:0] v;
        v = '0;
        for (int b = 0; b <= CS_N; b++) begin
            if (b < 4) v[b] = idx[b];
        end
        return v;
    endfunction

    assign w_wr_ok = bus.wr_en && (bus.wr_addr != 4'd0);

    // Lookup reads the pre-edge contents, so a same-edge patch is seen one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cs <= '0;
            for (int i = 0; i < 16; i++) begin
                r_table[i] <= dflt(4'(i));
            end
        end else begin
            r_cs <= r_table[bus.opcode];
            if (w_wr_ok) begin
                r_table[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.control_signals = r_cs;
endmodule

// File: tb/tb_microcode_rom.sv
// Scoreboard bench for microcode_rom: CS_N=1 and CS_N=7 instances driven in lockstep
// with directed lookups and patches; a negedge monitor pops expected words.
module tb_microcode_rom;
    logic clk;
    logic rst_n;

    microcode_rom_if #(.CS_N(1)) bus1 ();
    microcode_rom_if #(.CS_N(7)) bus7 ();

    microcode_rom #(.CS_N(1)) u_rom1 (.clk(clk), .reset(rst_n), .bus(bus1.slave));
    microcode_rom #(.CS_N(7)) u_rom7 (.clk(clk), .reset(rst_n), .bus(bus7.slave));

    logic [1:0] q1 [$];
    logic [7:0] q7 [$];
    logic       iss;
    logic       pend;
    int         n_vec;
    int         n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pend <= iss;

    // Monitor: one lookup result per edge that had a lookup issued.
    always @(negedge clk) begin
        if (pend) begin
            logic [1:0] e1;
            logic [7:0] e7;
            n_vec = n_vec + 2;
            if (q1.size() == 0 || q7.size() == 0) begin
                n_bad = n_bad + 2;
                $display("FAIL scoreboard_empty: got output %h/%h with no expected entry",
                         bus1.control_signals, bus7.control_signals);
            end else begin
                e1 = q1.pop_front();
                e7 = q7.pop_front();
                if (bus1.control_signals !== e1) begin
                    n_bad = n_bad + 1;
                    $display("FAIL cs1_lookup: got %b expected %b at %0t",
                             bus1.control_signals, e1, $time);
                end
                if (bus7.control_signals !== e7) begin
                    n_bad = n_bad + 1;
                    $display("FAIL cs7_lookup: got %h expected %h at %0t",
                             bus7.control_signals, e7, $time);
                end
            end
        end
    end

    task automatic step(input logic [3:0] op, input logic we, input logic [3:0] wa,
                        input logic [7:0] wd, input logic chk,
                        input logic [1:0] e1, input logic [7:0] e7);
        @(posedge clk);
        #2;
        bus1.opcode  = op;      bus7.opcode  = op;
        bus1.wr_en   = we;      bus7.wr_en   = we;
        bus1.wr_addr = wa;      bus7.wr_addr = wa;
        bus1.wr_data = wd[1:0]; bus7.wr_data = wd;
        iss = chk;
        if (chk) begin
            q1.push_back(e1);
            q7.push_back(e7);
        end
    endtask

    task automatic look(input logic [3:0] op, input logic [1:0] e1, input logic [7:0] e7);
        step(op, 1'b0, 4'd0, 8'h00, 1'b1, e1, e7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        iss   = 1'b0;
        rst_n = 1'b0;
        bus1.opcode = '0; bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
        bus7.opcode = '0; bus7.wr_en = 1'b0; bus7.wr_addr = '0; bus7.wr_data = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Default table
        look(4'd0,  2'b00, 8'h00);
        look(4'd1,  2'b01, 8'h01);
        look(4'd2,  2'b10, 8'h02);
        look(4'd3,  2'b11, 8'h03);
        look(4'd5,  2'b01, 8'h05);
        look(4'd6,  2'b10, 8'h06);
        look(4'd15, 2'b11, 8'h0F);

        // Patch entry 3, neighbours untouched
        step(4'd0, 1'b1, 4'd3, 8'h00, 1'b1, 2'b00, 8'h00);
        look(4'd3,  2'b00, 8'h00);
        look(4'd2,  2'b10, 8'h02);

        // Same-edge write and lookup to entry 7
        step(4'd7, 1'b1, 4'd7, 8'h00, 1'b1, 2'b11, 8'h07);
        look(4'd7,  2'b00, 8'h00);

        // Entry 0 is write-protected
        step(4'd0, 1'b1, 4'd0, 8'hFF, 1'b1, 2'b00, 8'h00);
        look(4'd0,  2'b00, 8'h00);

        // Write to another address leaves the concurrent lookup alone
        step(4'd5, 1'b1, 4'd6, 8'hA7, 1'b1, 2'b01, 8'h05);
        look(4'd6,  2'b11, 8'hA7);

        // Asynchronous reset mid-cycle with nonzero output
        step(4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 2'b00, 8'h00);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus1.wr_en = 1'b1; bus1.wr_addr = 4'd5; bus1.wr_data = 2'b00;
        bus7.wr_en = 1'b1; bus7.wr_addr = 4'd5; bus7.wr_data = 8'h00;
        #1;
        n_vec = n_vec + 2;
        if (bus1.control_signals !== 2'b00) begin
            n_bad = n_bad + 1;
            $display("FAIL cs1_async_reset: got %b expected 00", bus1.control_signals);
        end
        if (bus7.control_signals !== 8'h00) begin
            n_bad = n_bad + 1;
            $display("FAIL cs7_async_reset: got %h expected 00", bus7.control_signals);
        end
        repeat (2) @(posedge clk);
        #2;
        bus1.wr_en = 1'b0; bus7.wr_en = 1'b0;
        rst_n = 1'b1;

        // Patches discarded, write during reset ignored
        look(4'd3,  2'b11, 8'h03);
        look(4'd7,  2'b11, 8'h07);
        look(4'd6,  2'b10, 8'h06);
        look(4'd5,  2'b01, 8'h05);
        look(4'd0,  2'b00, 8'h00);

        step(4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 2'b00, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        n_vec = n_vec + 1;
        if (q1.size() != 0 || q7.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
                     q1.size(), q7.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/microcode_rom.md
Name: microcode_rom

Overview:
- Microcode store for the control unit: maps a 4-bit microcode opcode to a registered control-signal word.
- The control unit's metadata lookup drives `opcode`. Opcode 0 is the fetch/idle phase. The output fans out to the datapath as `control_signals`.
- The 16-entry table has reset-time default contents and can be rewritten at run time through a write port for microcode patching.

Parameters:
- CS_N, default 1: index of the MSB of the control word. Word width is CS_N+1. Legal range is CS_N >= 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low clears state immediately.
- opcode  input  4  microcode address to look up.
- wr_en  input  1  table write enable, sampled on the rising clk edge.
- wr_addr  input  4  table entry to write.
- wr_data  input  CS_N+1  new control word for entry wr_addr.
- control_signals  output  CS_N+1  registered control word for the opcode sampled on the previous edge.

Behaviour:
- Storage: 16 entries, each CS_N+1 bits wide.
- Default contents:
  - entry i holds i zero-extended to CS_N+1 bits, truncated to the low CS_N+1 bits if narrower.
  - Example for CS_N=1: entry 5 = 2'b01, entry 6 = 2'b10.
  - Entry 0 is always all-zero.
- Reset:
  - While reset=0, asynchronously and immediately control_signals is forced to 0 and all 16 entries reload their default contents.
  - Writes and lookups are ignored while reset=0.
  - Reset is asserted asynchronously; release takes effect at the next rising edge. The first lookup is registered on that edge.
- Lookup:
  - On each rising clk edge with reset=1, control_signals <= table[opcode].
  - Latency is exactly 1 cycle. The output is glitch-free (fully registered).
  - The output holds its value between edges.
- Write:
  - On a rising edge with reset=1 and wr_en=1, table[wr_addr] <= wr_data.
  - A write to wr_addr=0 is silently ignored, so entry 0 stays hardwired to 0 and the fetch phase always issues no control.
- Same-edge write and lookup to the same address: the lookup returns the OLD contents (read-before-write). The new word is visible on a lookup at the next edge.
- Writes to other addresses never affect the concurrent lookup.
- Written values persist until overwritten or until reset.
- Reset mid-operation discards every patched entry.
- No X propagation: every entry and the output are defined from reset onward. All 16 opcode values are valid; there is no illegal-opcode handling.

Test Plan:
- Reset: drive reset=0 asynchronously mid-cycle with control_signals nonzero -> control_signals=0 before the next clk edge. Release reset; opcode=0 -> 0 after 1 edge.
- Default table, CS_N=1: apply opcodes 1,2,3,5,6 on consecutive edges -> control_signals = 01,10,11,01,10, each 1 cycle after its opcode.
- Patch: wr_en=1, wr_addr=3, wr_data=2'b00; next cycle opcode=3 -> 00. Other entries unchanged, e.g. opcode 2 -> 10.
- Same-edge conflict: opcode=7 and write 7<-2'b00 on the same edge -> output 11 (old value). opcode=7 on the next edge -> 00.
- Entry-0 protection: write 0<-2'b11, then opcode=0 -> 00.
- Reset after patch: patch entry 3, pulse reset low, release, then opcode=3 -> default 11 restored. Repeat the default-table check with CS_N=7: opcode 15 -> 8'h0F.
